// File: rtl/imem_sync_rw.sv
// ---------------------------------------------------------------------------
// imem_sync_rw
//   Word-organised instruction/data memory with byte-addressed ports.
//   - One-cycle registered read port with a valid/ready handshake.
//   - Write port with per-byte strobes.
//   - Sequential hardware clear engine: it zeroes one word per cycle after
//     reset and on every clr_start pulse.
//   Reads and writes return the data stored before the write (read-first),
//   so the array can map onto block RAM.
//
// Optional feature (macro IMEM_PARITY_EN):
//   Each byte stores one even-parity bit. This adds the input inj_perr
//   (inverts the stored parity of lane 0 on a write) and the output rd_perr
//   (parity mismatch on the returned word).
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous, active-low reset
//   clr_start  pulse that starts a clear of all words
//   busy       high while a clear is in progress
//   rd_req     read request         rd_addr   byte address of the read
//   rd_gnt     read accepted this cycle (combinational)
//   rd_valid   rd_data/rd_err valid rd_ready  consumer takes rd_data
//   rd_data    read word            rd_err    misaligned/out-of-range read
//   we         write enable         wr_addr   byte address of the write
//   wr_din     write data           wr_be     byte strobes
//   wr_err     registered pulse: write dropped (bad address or busy)
// ---------------------------------------------------------------------------
module imem_sync_rw #(
   parameter int DEPTH  = 128,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 12
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                clr_start,
   output logic                busy,
   input  logic                rd_req,
   input  logic [ADDR_W-1:0]   rd_addr,
   output logic                rd_gnt,
   output logic                rd_valid,
   input  logic                rd_ready,
   output logic [DATA_W-1:0]   rd_data,
   output logic                rd_err,
   input  logic                we,
   input  logic [ADDR_W-1:0]   wr_addr,
   input  logic [DATA_W-1:0]   wr_din,
   input  logic [DATA_W/8-1:0] wr_be,
   output logic                wr_err
`ifdef IMEM_PARITY_EN
   ,
   input  logic                inj_perr,
   output logic                rd_perr
`endif
);

   localparam int NB  = DATA_W / 8;
   localparam int OFS = $clog2(NB);
   localparam int IDX = $clog2(DEPTH);
   localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((1 << OFS) - 1);

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // A byte address is bad if it is not word-aligned or points past the array.
   function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
      return ((a & OFS_MASK) != '0) || ((a >> (OFS + IDX)) != '0);
   endfunction

   state_t             r_state, w_state_nxt;
   logic [IDX-1:0]     r_clr_ptr, w_clr_ptr_nxt;
   logic               r_rd_valid;
   logic [DATA_W-1:0]  r_rd_data;
   logic               r_rd_err;
   logic               r_wr_err;
   logic [DATA_W-1:0]  r_mem [DEPTH];

   logic               w_busy;
   logic               w_rd_bad;
   logic               w_wr_bad;
   logic               w_wr_ok;
   logic [IDX-1:0]     w_rd_idx;
   logic [IDX-1:0]     w_wr_idx;

   assign w_busy   = (r_state == ST_CLEAR);
   assign w_rd_bad = addr_bad(rd_addr);
   assign w_wr_bad = addr_bad(wr_addr);
   assign w_rd_idx = rd_addr[OFS+IDX-1:OFS];
   assign w_wr_idx = wr_addr[OFS+IDX-1:OFS];
   // A write in the same cycle as clr_start still lands; the clear then
   // overwrites it.
   assign w_wr_ok  = !w_busy && we && !w_wr_bad;

   // A new read is accepted only when the output register is free or is
   // being emptied this cycle.
   assign rd_gnt   = rd_req && !w_busy && (!r_rd_valid || rd_ready);

   assign busy     = w_busy;
   assign rd_valid = r_rd_valid;
   assign rd_data  = r_rd_data;
   assign rd_err   = r_rd_err;
   assign wr_err   = r_wr_err;

   // ---------------- clear engine next state -------------------------------
   always_comb begin
      // NOTE: every combinational output gets a default before any branch,
      // so no path leaves one unassigned and no latch is inferred.
      w_state_nxt   = r_state;
      w_clr_ptr_nxt = r_clr_ptr;
      case (r_state)
         ST_CLEAR: begin
            if (clr_start) begin
               w_clr_ptr_nxt = '0;
            end else if (r_clr_ptr == IDX'(DEPTH - 1)) begin
               w_state_nxt   = ST_RUN;
               w_clr_ptr_nxt = '0;
            end else begin
               w_clr_ptr_nxt = r_clr_ptr + IDX'(1);
            end
         end
         ST_RUN: begin
            if (clr_start) begin
               w_state_nxt   = ST_CLEAR;
               w_clr_ptr_nxt = '0;
            end
         end
      endcase
   end

`ifdef IMEM_PARITY_EN
   logic [NB-1:0] r_par [DEPTH];
   logic          r_rd_perr;
   logic          w_rd_perr;

   // Recompute the parity of the addressed word and compare it with the
   // stored parity bits.
   always_comb begin
      w_rd_perr = 1'b0;
      for (int i = 0; i < NB; i++) begin
         w_rd_perr = w_rd_perr | (r_par[w_rd_idx][i] ^ (^r_mem[w_rd_idx][8*i +: 8]));
      end
   end

   assign rd_perr = r_rd_perr;
`endif

   // ---------------- storage array -----------------------------------------
   // NOTE: the array has no reset. A reset would stop it from mapping onto
   // block RAM. The clear engine zeroes it instead.
   always_ff @(posedge clk) begin
      if (w_busy) begin
         r_mem[r_clr_ptr] <= '0;
`ifdef IMEM_PARITY_EN
         r_par[r_clr_ptr] <= '0;
`endif
      end else if (w_wr_ok) begin
         for (int i = 0; i < NB; i++) begin
            if (wr_be[i]) begin
               r_mem[w_wr_idx][8*i +: 8] <= wr_din[8*i +: 8];
`ifdef IMEM_PARITY_EN
               r_par[w_wr_idx][i] <= (^wr_din[8*i +: 8]) ^ ((i == 0) && inj_perr);
`endif
            end
         end
      end
   end

   // ---------------- control and read output registers ---------------------
   // NOTE: sequential state uses non-blocking assignments. Every register
   // then samples the values from before the edge, and that is what gives
   // the read-first behaviour against the array write above.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state    <= ST_CLEAR;
         r_clr_ptr  <= '0;
         r_rd_valid <= 1'b0;
         r_rd_data  <= '0;
         r_rd_err   <= 1'b0;
         r_wr_err   <= 1'b0;
`ifdef IMEM_PARITY_EN
         r_rd_perr  <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_clr_ptr <= w_clr_ptr_nxt;
         r_wr_err  <= we && (w_busy || w_wr_bad);
         if (rd_gnt) begin
            r_rd_valid <= 1'b1;
            r_rd_err   <= w_rd_bad;
            r_rd_data  <= w_rd_bad ? '0 : r_mem[w_rd_idx];
`ifdef IMEM_PARITY_EN
            r_rd_perr  <= !w_rd_bad && w_rd_perr;
`endif
         end else if (rd_ready) begin
            r_rd_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_imem_sync_rw.sv
// ---------------------------------------------------------------------------
// tb_imem_sync_rw
//   Scoreboard bench for imem_sync_rw (DEPTH=128, DATA_W=32, ADDR_W=12).
//   The stimulus process pushes the expected response when a read is
//   granted. The monitor pops and compares on every rd_valid & rd_ready
//   handshake. Inputs are driven 1 time unit after the rising edge and
//   outputs are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_imem_sync_rw;

   localparam int DEPTH  = 128;
   localparam int DATA_W = 32;
   localparam int ADDR_W = 12;
   localparam int NB     = DATA_W / 8;

   typedef struct {
      logic [DATA_W-1:0] data;
      logic              err;
      logic              perr;
   } exp_t;

   logic              clk = 1'b0;
   logic              reset;
   logic              clr_start;
   logic              busy;
   logic              rd_req;
   logic [ADDR_W-1:0] rd_addr;
   logic              rd_gnt;
   logic              rd_valid;
   logic              rd_ready;
   logic [DATA_W-1:0] rd_data;
   logic              rd_err;
   logic              we;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_din;
   logic [NB-1:0]     wr_be;
   logic              wr_err;
`ifdef IMEM_PARITY_EN
   logic              inj_perr;
   logic              rd_perr;
`endif

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   busy_n;
   int   gnt_bad;

   always #5 clk = ~clk;

   imem_sync_rw #(.DEPTH(DEPTH), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .clr_start (clr_start),
      .busy      (busy),
      .rd_req    (rd_req),
      .rd_addr   (rd_addr),
      .rd_gnt    (rd_gnt),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_err    (rd_err),
      .we        (we),
      .wr_addr   (wr_addr),
      .wr_din    (wr_din),
      .wr_be     (wr_be),
      .wr_err    (wr_err)
`ifdef IMEM_PARITY_EN
      ,
      .inj_perr  (inj_perr),
      .rd_perr   (rd_perr)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Issue one read, wait (bounded) for its grant, and record the expected response.
   task automatic rd_issue(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                           input logic err, input logic perr);
      bit got = 1'b0;
      rd_req  = 1'b1;
      rd_addr = a;
      for (int i = 0; i < 300 && !got; i++) begin
         @(negedge clk);
         if (rd_gnt) begin
            exp_q.push_back('{d, err, perr});
            got = 1'b1;
         end
      end
      check("rd_grant", got, 1);
      tick();
      rd_req = 1'b0;
   endtask

   // One write, then check the wr_err pulse and that it drops again.
   task automatic wr(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                     input logic [NB-1:0] be, input logic exp_err);
      we = 1'b1; wr_addr = a; wr_din = d; wr_be = be;
      tick();
      we = 1'b0; wr_be = '0;
      @(negedge clk);
      check("wr_err", wr_err, exp_err);
      tick();
      @(negedge clk);
      check("wr_err_pulse", wr_err, 0);
      tick();
   endtask

   task automatic drain();
      int i = 0;
      while (exp_q.size() != 0 && i < 50) begin
         @(negedge clk);
         i++;
      end
      check("scoreboard_drain", exp_q.size(), 0);
      tick();
   endtask

   task automatic count_busy(output int n, output int bad);
      n   = 0;
      bad = 0;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (!busy) break;
         n++;
         if (rd_gnt) bad++;
      end
   endtask

   // Monitor: every completed handshake must match the oldest expectation.
   initial begin
      forever begin
         @(negedge clk);
         if (rd_valid && rd_ready) begin
            check("rd_expected", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               mon_e = exp_q.pop_front();
               check("rd_data", rd_data, mon_e.data);
               check("rd_err", rd_err, mon_e.err);
`ifdef IMEM_PARITY_EN
               check("rd_perr", rd_perr, mon_e.perr);
`endif
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; clr_start = 1'b0; rd_req = 1'b1; rd_addr = '0; rd_ready = 1'b1;
      we = 1'b0; wr_addr = '0; wr_din = '0; wr_be = '0;
`ifdef IMEM_PARITY_EN
      inj_perr = 1'b0;
`endif
      // Values while reset is held.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", busy, 1);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      check("rst_rd_err", rd_err, 0);
      check("rst_wr_err", wr_err, 0);
      check("rst_rd_gnt", rd_gnt, 0);

      // Clear after release: busy for exactly DEPTH cycles, no grants, then grant.
      tick();
      reset = 1'b1;
      count_busy(busy_n, gnt_bad);
      check("init_busy_cycles", busy_n, DEPTH);
      check("init_gnt_while_busy", gnt_bad, 0);
      check("init_first_gnt", rd_gnt, 1);
      if (rd_gnt) exp_q.push_back('{32'h0, 1'b0, 1'b0});
      tick();
      rd_req = 1'b0;
      drain();

      // Full-word write, then a single-lane write.
      wr(12'h010, 32'hDEADBEEF, 4'hF, 1'b0);
      wr(12'h010, 32'h0000AA00, 4'b0010, 1'b0);
      rd_issue(12'h010, 32'hDEADAAEF, 1'b0, 1'b0);
      // An all-zero strobe is a legal no-op.
      wr(12'h010, 32'h12345678, 4'h0, 1'b0);
      rd_issue(12'h010, 32'hDEADAAEF, 1'b0, 1'b0);

      // Bad addresses.
      rd_issue(12'h011, 32'h0, 1'b1, 1'b0);
      rd_issue(12'h200, 32'h0, 1'b1, 1'b0);
      wr(12'h202, 32'hFFFFFFFF, 4'hF, 1'b1);
      rd_issue(12'h000, 32'h0, 1'b0, 1'b0);
      rd_issue(12'h1FC, 32'h0, 1'b0, 1'b0);
      drain();

      // Back-to-back reads with a two-cycle stall on the second one.
      wr(12'h000, 32'h0BADF00D, 4'hF, 1'b0);
      wr(12'h004, 32'h22222222, 4'hF, 1'b0);
      wr(12'h008, 32'h33333333, 4'hF, 1'b0);
      rd_issue(12'h000, 32'h0BADF00D, 1'b0, 1'b0);
      rd_issue(12'h004, 32'h22222222, 1'b0, 1'b0);
      rd_ready = 1'b0;
      rd_req   = 1'b1;
      rd_addr  = 12'h008;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         check("stall_gnt", rd_gnt, 0);
         check("stall_valid", rd_valid, 1);
         check("stall_data", rd_data, 32'h22222222);
         tick();
      end
      rd_ready = 1'b1;
      rd_issue(12'h008, 32'h33333333, 1'b0, 1'b0);
      drain();

      // Read and write of the same word in one cycle return the old contents.
      we = 1'b1; wr_addr = 12'h004; wr_din = 32'h11111111; wr_be = 4'hF;
      rd_req = 1'b1; rd_addr = 12'h004;
      @(negedge clk);
      check("rw_same_gnt", rd_gnt, 1);
      if (rd_gnt) exp_q.push_back('{32'h22222222, 1'b0, 1'b0});
      tick();
      we = 1'b0; wr_be = '0; rd_req = 1'b0;
      rd_issue(12'h004, 32'h11111111, 1'b0, 1'b0);
      drain();

      // Clear with a write in the same cycle, then reset partway through the clear.
      wr(12'h00C, 32'h77777777, 4'hF, 1'b0);
      clr_start = 1'b1;
      we = 1'b1; wr_addr = 12'h008; wr_din = 32'h55555555; wr_be = 4'hF;
      tick();
      clr_start = 1'b0; we = 1'b0; wr_be = '0;
      repeat (49) tick();
      @(negedge clk);
      check("clear_mid_busy", busy, 1);
      tick();
      reset = 1'b0;
      @(negedge clk);
      check("clear_rst_busy", busy, 1);
      tick();
      reset  = 1'b1;
      rd_req = 1'b1;
      rd_addr = 12'h008;
      count_busy(busy_n, gnt_bad);
      check("reclear_busy_cycles", busy_n, DEPTH);
      check("reclear_gnt_while_busy", gnt_bad, 0);
      check("reclear_first_gnt", rd_gnt, 1);
      if (rd_gnt) exp_q.push_back('{32'h0, 1'b0, 1'b0});
      tick();
      rd_req = 1'b0;
      rd_issue(12'h000, 32'h0, 1'b0, 1'b0);
      rd_issue(12'h004, 32'h0, 1'b0, 1'b0);
      rd_issue(12'h00C, 32'h0, 1'b0, 1'b0);
      rd_issue(12'h010, 32'h0, 1'b0, 1'b0);
      rd_issue(12'h1FC, 32'h0, 1'b0, 1'b0);
      drain();

`ifdef IMEM_PARITY_EN
      // A clean word reads without a parity error; an injected fault is flagged.
      wr(12'h020, 32'hA5A5A5A5, 4'hF, 1'b0);
      rd_issue(12'h020, 32'hA5A5A5A5, 1'b0, 1'b0);
      inj_perr = 1'b1;
      wr(12'h024, 32'h01020304, 4'hF, 1'b0);
      inj_perr = 1'b0;
      rd_issue(12'h024, 32'h01020304, 1'b0, 1'b1);
      drain();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imem_sync_rw.md
Name: imem_sync_rw

Overview:
- Parametrised, word-organised instruction/data memory with byte-addressed ports and per-byte write strobes.
- Has a registered (1-cycle) read port with valid/ready handshake and a sequential hardware clear engine.
- Replaces the combinational-read, all-at-once-reset memory in the core's fetch path, so that it maps to block RAM.
- Preloading is done through the write port by the loader/testbench.

Parameters:
- DEPTH, 128, number of words; power of two, >= 4
- DATA_W, 32, word width in bits; multiple of 8
- ADDR_W, 12, byte-address width; must be >= $clog2(DEPTH)+$clog2(DATA_W/8)
- Derived: NB = DATA_W/8 byte lanes; OFS = $clog2(NB) offset bits; IDX = $clog2(DEPTH)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- clr_start  in  1  pulse; starts a hardware clear of all words
- busy  out  1  high while clear is in progress
- rd_req  in  1  read request
- rd_addr  in  ADDR_W  byte address of read
- rd_gnt  out  1  request accepted this cycle (combinational)
- rd_valid  out  1  rd_data/rd_err valid
- rd_ready  in  1  consumer accepts rd_data
- rd_data  out  DATA_W  read word
- rd_err  out  1  misaligned or out-of-range read
- we  in  1  write enable
- wr_addr  in  ADDR_W  byte address of write
- wr_din  in  DATA_W  write data
- wr_be  in  NB  byte strobes; bit i controls bits [8i+7:8i]
- wr_err  out  1  registered pulse: write dropped (misaligned/out-of-range/busy)

Behaviour:
- Reset: asynchronous, active-low (reset=0) on clk domain. While asserted: state=CLEAR, clr_ptr=0, busy=1, rd_valid=0, rd_data=0, rd_err=0, wr_err=0. Memory contents are not reset directly.
- FSM CLEAR: each cycle writes 0 to mem[clr_ptr], then clr_ptr++. After writing DEPTH-1, go to RUN the next cycle. The clear takes exactly DEPTH cycles after reset release.
- FSM RUN: busy=0. clr_start=1 -> CLEAR with clr_ptr=0.
- clr_start during CLEAR restarts clr_ptr at 0.
- Reset mid-clear restarts the clear from 0.
- Word index = addr[OFS+IDX-1:OFS].
  - Misaligned: addr[OFS-1:0] != 0.
  - Out of range: addr[ADDR_W-1:OFS+IDX] != 0.
- Read accept: rd_gnt = rd_req & ~busy & (~rd_valid | rd_ready).
- On an accepted read, the next edge loads rd_valid=1 and rd_data=mem[idx], or rd_data=0 with rd_err=1 if the address is bad. Latency is 1 cycle.
- Back-to-back reads are supported: a new read is accepted in the same cycle rd_valid & rd_ready.
- rd_valid=1 & rd_ready=0: rd_data and rd_err hold, and rd_gnt=0.
- rd_valid clears on rd_ready with no new grant.
- An outstanding rd_valid survives clr_start and completes its handshake. No new grants are issued while busy.
- Write: when RUN & we & address good, each lane with wr_be[i]=1 is updated at the edge.
  - wr_be=0 is a legal no-op with no error.
  - A bad address, or we while busy, drops the write and sets wr_err=1 for one cycle.
- Same-cycle read and write to one word: read-first, so rd_data returns the old contents.
- A write in the same cycle as clr_start (RUN) is performed, then the clear overwrites it.

Optional Feature:
- Macro: IMEM_PARITY_EN.
- Defined: each byte stores an extra even-parity bit, computed on write and zeroed with correct parity by the clear.
  - Adds output rd_perr (1 bit), registered alongside rd_data and valid with rd_valid.
  - rd_perr=1 when any lane's stored parity mismatches the recomputed parity.
  - Adds input inj_perr (1 bit). When high during a write, it inverts the stored parity of lane 0 (fault injection).
  - rd_perr resets to 0.
- Undefined: no parity storage; the rd_perr and inj_perr ports are absent.

Test Plan:
- Release reset, hold rd_req=1, addr 0x000 -> busy=1 for exactly 128 cycles with rd_gnt=0; first grant in cycle 129; rd_data=0x00000000 one cycle later.
- Write 0xDEADBEEF at 0x010 with wr_be=4'hF, then wr_be=4'b0010 with wr_din 0x0000AA00 -> read 0x010 returns 0xDEADAAEF.
- Read 0x011 and 0x200 -> rd_err=1, rd_data=0 on each. Write 0x202 -> wr_err pulse, no memory change.
- Reads of 0x0,0x4,0x8 with rd_ready low for 2 cycles on the second -> rd_data stable, rd_gnt=0 while stalled, output order preserved with no loss or duplication.
- Write 0x11111111 and read 0x004 in the same cycle over old 0x22222222 -> returns 0x22222222; next read returns 0x11111111.
- clr_start after filling words, with reset pulsed at clear cycle 50 -> clear restarts, busy for 128 cycles after release, then all words read 0. With IMEM_PARITY_EN: write with inj_perr=1 then read -> rd_perr=1.
